wrr_hold_arbiter: RTL
=====================

// Module: wrr_hold_arbiter
// PURPOSE
//  Weighted round-robin arbiter that shares one resource (for example a bus or memory port) among N requesters.
//  A grant is a tenure: it is held until the owner signals done, drops its req, or hits a hold timeout.
//  Each requester may win up to weight[i] consecutive tenures before priority rotates to the next index.
//  Sits between the requester blocks and the shared-resource mux; owner drives the mux select.
// PARAMETERS
//  N         4   number of requesters (>=2)
//  WW        3   width of each weight field; effective weight = max(weight[i],1)
//  MAX_HOLD  16  maximum tenure length in cycles before forced release (>=2)
// PORTS
//  clk      in   1      clock, rising edge
//  rst      in   1      asynchronous, active-low reset
//  req      in   N      request vector, bit i = requester i
//  weight   in   N*WW   weight of requester i at [i*WW +: WW], read combinationally at each decision
//  done     in   1      current owner releases the resource; ignored when busy=0
//  Grant    out  N      registered one-hot grant, 0 when idle
//  owner    out  clog2N index of the granted requester, 0 when idle
//  busy     out  1      |Grant
//  timeout  out  1      one-cycle pulse in the cycle after a forced release
// BEHAVIOUR
//  Reset (rst=0, asynchronous, no clock needed):
//   - Grant=0, owner=0, busy=0, timeout=0, hold_cnt=0.
//   - last=N-1; used=all-ones, so priority starts at index 0.
//  State machine: IDLE (Grant==0) and OWNED (Grant!=0). All outputs are registered.
//  Decision point (a rising edge that is either of):
//   - IDLE with |req=1.
//   - OWNED with a release.
//  Release in OWNED (first matching rule wins):
//   a) done=1 -> normal release.
//   b) req[owner]=0 -> normal release.
//   c) hold_cnt==MAX_HOLD-1 -> forced release: timeout=1 next cycle; used forced to all-ones.
//   - done together with the timeout condition counts as (a); no timeout pulse.
//  Arbitration at a decision point:
//   - start = (used < W(last)) ? last : (last+1) mod N, where W(i)=max(weight[i],1).
//   - winner = first index with req=1, searching cyclically from start.
//   - The releasing owner is eligible if its req is still 1.
//   - winner==last -> used=used+1, saturating at all-ones. Otherwise last=winner, used=1.
//   - Grant/owner update at the same edge: no dead cycle between tenures.
//   - No req=1 at a decision point -> Grant=0, enter IDLE; last and used are kept.
//  Latency: req sampled at edge k in IDLE -> Grant valid after edge k.
//  hold_cnt:
//   - Cleared at every new tenure, including a re-grant to the same index.
//   - Incremented each OWNED cycle without a release.
//   - Width clog2(MAX_HOLD).
//  Without a release, Grant is stable regardless of changes to other req bits or to weights.
//  Weight changes take effect at the next decision point only.
//  Asynchronous reset mid-tenure drops Grant immediately; after reset release, arbitration restarts from index 0.
// TESTING
//  1. Hold rst=0 for 3 cycles with req=1111 -> Grant=0, busy=0, timeout=0; release rst -> Grant=0001 after the next edge.
//  2. All weights=1, req=1111, done=1 every OWNED cycle -> Grant sequence 0001,0010,0100,1000,0001.
//  3. weight0=3, others=1, req=1111, done each cycle -> Grant sequence 0001,0001,0001,0010,0100,1000,0001.
//  4. MAX_HOLD=4, req=0100, done=0 -> Grant=0100 for 4 cycles, then timeout=1 for 1 cycle.
//     Grant stays 0100 (re-granted, only requester) and hold_cnt restarts at 0.
//  5. req=0011 with owner 0 granted; drop req[0] -> Grant=0010 after that edge, timeout=0.
//  6. Assert rst=0 mid-tenure between clock edges -> Grant=0 without a clock edge.
//     With req=1010 after reset release -> Grant=0010. weight=0 behaves identically to weight=1.

Source files
------------

// File: rtl/wrr_hold_arbiter.sv
// Weighted round-robin arbiter with held tenures: a grant lasts until done,
// request drop, or a hold timeout; each index may win up to weight[i] tenures in a row.
//
// state | meaning
// IDLE  | no grant outstanding, waiting for any req
// OWNED | one requester holds the resource
module wrr_hold_arbiter #(
    parameter int N        = 4,
    parameter int WW       = 3,
    parameter int MAX_HOLD = 16,
    localparam int IW      = (N > 1) ? $clog2(N) : 1,
    localparam int HW      = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    req,
    input  logic [N*WW-1:0] weight,
    input  logic            done,
    output logic [N-1:0]    Grant,
    output logic [IW-1:0]   owner,
    output logic            busy,
    output logic            timeout
);

    typedef enum logic {IDLE = 1'b0, OWNED = 1'b1} state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic            timeout_q, timeout_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;
    logic [IW-1:0]   last_q, last_d;
    logic [WW-1:0]   used_q, used_d;

    logic            release_normal;
    logic            release_forced;
    logic            decision;
    logic [WW-1:0]   used_eff;
    logic [WW-1:0]   w_last;
    logic [IW-1:0]   start;
    logic [IW-1:0]   winner;
    logic            found;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            owner_q    <= '0;
            timeout_q  <= 1'b0;
            hold_cnt_q <= '0;
            last_q     <= IW'(N - 1);
            used_q     <= '1;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            owner_q    <= owner_d;
            timeout_q  <= timeout_d;
            hold_cnt_q <= hold_cnt_d;
            last_q     <= last_d;
            used_q     <= used_d;
        end
    end

    always_comb begin
        release_normal = 1'b0;
        release_forced = 1'b0;
        decision       = 1'b0;
        used_eff       = used_q;
        w_last         = '0;
        start          = '0;
        winner         = '0;
        found          = 1'b0;

        state_d    = state_q;
        grant_d    = grant_q;
        owner_d    = owner_q;
        timeout_d  = 1'b0;
        hold_cnt_d = hold_cnt_q;
        last_d     = last_q;
        used_d     = used_q;

        if (state_q == OWNED) begin
            release_normal = done || !req[owner_q];
            release_forced = !release_normal && (hold_cnt_q == HW'(MAX_HOLD - 1));
            decision       = release_normal || release_forced;
        end else begin
            decision = |req;
        end

        // A forced release exhausts the owner's quota so priority moves on.
        if (release_forced) used_eff = '1;

        w_last = weight[int'(last_q)*WW +: WW];
        if (w_last == '0) w_last = WW'(1);

        if (used_eff < w_last)
            start = last_q;
        else if (int'(last_q) == N - 1)
            start = '0;
        else
            start = last_q + IW'(1);

        for (int k = 0; k < N; k++) begin
            int idx;
            idx = int'(start) + k;
            if (idx >= N) idx = idx - N;
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = IW'(idx);
            end
        end

        if (decision) begin
            timeout_d  = release_forced;
            hold_cnt_d = '0;
            if (found) begin
                state_d = OWNED;
                grant_d = '0;
                grant_d[winner] = 1'b1;
                owner_d = winner;
                if (winner == last_q) begin
                    used_d = (&used_eff) ? used_eff : used_eff + WW'(1);
                end else begin
                    last_d = winner;
                    used_d = WW'(1);
                end
            end else begin
                state_d = IDLE;
                grant_d = '0;
                owner_d = '0;
                used_d  = used_eff;
            end
        end else if (state_q == OWNED) begin
            hold_cnt_d = hold_cnt_q + HW'(1);
        end
    end

    assign Grant   = grant_q;
    assign owner   = owner_q;
    assign busy    = |grant_q;
    assign timeout = timeout_q;

endmodule
